// File: rtl/issuediv_pkg.sv
// Shared types and constants for the iterative divide issue unit.
// Holds the FSM state encoding, default widths and result field offsets.
package issuediv_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 6;

    // issuediv_out layout: {remainder, quotient}
    localparam int QUO_LSB = 0;
    localparam int REM_LSB = DEF_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/issuediv_iter_div_step.sv
// Single radix-2 restoring step: shift in one dividend bit, compare, and
// conditionally subtract the divisor.
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0] prem_in,
    input  logic       dvd_bit,
    input  logic [W:0] divisor,
    output logic [W:0] prem_out,
    output logic       quo_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted  = {prem_in, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        quo_bit  = (shifted >= {1'b0, divisor});
        prem_out = quo_bit ? diff[W:0] : shifted[W:0];
    end

endmodule

// File: rtl/issuediv_iter.sv
// Iterative radix-2 restoring divide unit that holds its result for the CDB.
// Define ISSUEDIV_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module issuediv_iter
    import issuediv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issuediv_enable,
    input  logic [DATA_W-1:0]   issuediv_rsdata,
    input  logic [DATA_W-1:0]   issuediv_rtdata,
    input  logic [TAG_W-1:0]    issuediv_rdtag,
    input  logic                issuediv_cdb_grant,
    input  logic                issuediv_flush,
    output logic                issuediv_busy,
    output logic                issuediv_valid_out,
    output logic [2*DATA_W-1:0] issuediv_out,
    output logic [TAG_W-1:0]    issuediv_rdtag_out,
    output logic                issuediv_divzero
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam int REM_POS = REM_LSB - DEF_DATA_W + DATA_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  dvd_q, dvd_d;
    logic [DATA_W:0]    dvs_q, dvs_d;
    logic [DATA_W:0]    prem_q, prem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               divzero_q, divzero_d;

    logic [DATA_W-1:0]  rs_mag, rt_mag;
    logic [DATA_W:0]    step_prem;
    logic               step_bit;

`ifdef ISSUEDIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign rs_mag = issuediv_rsdata[DATA_W-1] ? -issuediv_rsdata : issuediv_rsdata;
    assign rt_mag = issuediv_rtdata[DATA_W-1] ? -issuediv_rtdata : issuediv_rtdata;
`else
    assign rs_mag = issuediv_rsdata;
    assign rt_mag = issuediv_rtdata;
`endif

    div_step #(.W(DATA_W)) u_step (
        .prem_in  (prem_q),
        .dvd_bit  (dvd_q[DATA_W-1]),
        .divisor  (dvs_q),
        .prem_out (step_prem),
        .quo_bit  (step_bit)
    );

    // The dividend register shifts left each step and collects quotient bits at the bottom.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        tag_d     = tag_q;
        divzero_d = divzero_q;
`ifdef ISSUEDIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        if (issuediv_flush) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issuediv_enable) begin
                        tag_d = issuediv_rdtag;
                        if (issuediv_rtdata == '0) begin
                            dvd_d     = '1;
                            prem_d    = {1'b0, issuediv_rsdata};
                            divzero_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            dvd_d     = rs_mag;
                            dvs_d     = {1'b0, rt_mag};
                            prem_d    = '0;
                            divzero_d = 1'b0;
                            count_d   = '0;
                            state_d   = ST_CALC;
`ifdef ISSUEDIV_SIGNED_EN
                            neg_quo_d = issuediv_rsdata[DATA_W-1] ^ issuediv_rtdata[DATA_W-1];
                            neg_rem_d = issuediv_rsdata[DATA_W-1];
`endif
                        end
                    end
                end
                ST_CALC: begin
                    dvd_d   = {dvd_q[DATA_W-2:0], step_bit};
                    prem_d  = step_prem;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        count_d = '0;
`ifdef ISSUEDIV_SIGNED_EN
                        state_d = ST_FIX;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
`ifdef ISSUEDIV_SIGNED_EN
                // Magnitude MIN/-1 already yields MIN with no negation, so no special case.
                ST_FIX: begin
                    dvd_d   = neg_quo_q ? -dvd_q : dvd_q;
                    prem_d  = {1'b0, (neg_rem_q ? -prem_q[DATA_W-1:0] : prem_q[DATA_W-1:0])};
                    state_d = ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (issuediv_cdb_grant) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            tag_q     <= '0;
            divzero_q <= 1'b0;
`ifdef ISSUEDIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            tag_q     <= tag_d;
            divzero_q <= divzero_d;
`ifdef ISSUEDIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // Result fields read as zero whenever nothing is being presented.
    always_comb begin
        issuediv_busy      = (state_q != ST_IDLE);
        issuediv_valid_out = (state_q == ST_DONE);
        issuediv_out       = '0;
        issuediv_rdtag_out = '0;
        issuediv_divzero   = 1'b0;
        if (issuediv_valid_out) begin
            issuediv_out[QUO_LSB +: DATA_W] = dvd_q;
            issuediv_out[REM_POS +: DATA_W] = prem_q[DATA_W-1:0];
            issuediv_rdtag_out              = tag_q;
            issuediv_divzero                = divzero_q;
        end
    end

endmodule
